// File: rtl/layer_serializer.sv
// layer_serializer: captures a full layer output word and replays it one element per cycle.
// Build macro LAYER_SER_RELU_EN clamps negative elements to zero as they are issued.
module layer_serializer #(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS-1:0]            in_valids,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in,
    input  logic                              stall,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_valid,
    output logic [31:0]                       addr_out,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun
);
    localparam int IW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] buffer [NUM_NEURONS];
    logic                  all_v, all_v_q, trig;
    logic [DATA_WIDTH-1:0] elem_raw, elem;

    assign all_v    = &in_valids;
    assign trig     = all_v & ~all_v_q;
    assign elem_raw = buffer[idx];
`ifdef LAYER_SER_RELU_EN
    assign elem = elem_raw[DATA_WIDTH-1] ? '0 : elem_raw;
`else
    assign elem = elem_raw;
`endif

    // Buffer is only written on a fresh capture, so overruns never disturb a stream in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && trig)
            for (int i = 0; i < NUM_NEURONS; i++)
                buffer[i] <= layer_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            all_v_q    <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            addr_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            all_v_q    <= all_v;
            busy       <= state != IDLE;
            done       <= state == DONE;
            data_valid <= state == STREAM && !stall;
            if (trig && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (trig) begin
                    idx   <= '0;
                    state <= LOAD;
                end
                LOAD: state <= STREAM;
                STREAM: if (!stall) begin
                    data_out <= elem;
                    addr_out <= 32'(idx);
                    if (idx == IW'(NUM_NEURONS - 1))
                        state <= DONE;
                    else
                        idx <= idx + 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed frames (basic, stall, held level, partial valid, overrun, resets).
// Values are sampled 1 time unit after each rising edge; "edge e" is counted from the capture edge T.
module tb_layer_serializer;
    localparam int N = 4;
    localparam int W = 16;

    localparam logic [63:0] FRAME_A = 64'h0004_0003_FFFE_0001;
    localparam logic [63:0] FRAME_B = 64'h8000_7FFF_FFFF_0000;
`ifdef LAYER_SER_RELU_EN
    localparam logic [63:0] EXP_A = 64'h0004_0003_0000_0001;
    localparam logic [63:0] EXP_B = 64'h0000_7FFF_0000_0000;
`else
    localparam logic [63:0] EXP_A = 64'h0004_0003_FFFE_0001;
    localparam logic [63:0] EXP_B = 64'h8000_7FFF_FFFF_0000;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_valids;
    logic [N*W-1:0] layer_in;
    logic          stall;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic [31:0]   addr_out;
    logic          busy;
    logic          done;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valids(in_valids),
        .layer_in(layer_in),
        .stall(stall),
        .data_out(data_out),
        .data_valid(data_valid),
        .addr_out(addr_out),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 0);
        check({tag, "_valid"}, 32'(data_valid), 0);
        check({tag, "_addr"}, addr_out, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    // Capture at edge T, then observe edges T+1..T+14 against the hand-computed schedule.
    task automatic run_frame(input logic [63:0] frame, input logic [63:0] want, input logic [15:0] stall_mask,
                             input int done_edge, input int hold, input int ov_edge);
        int k;
        bit exp_v;
        k = 0;
        layer_in  = frame;
        in_valids = '1;
        stall     = 1'b0;
        tick();
        check("busy_T", 32'(busy), 0);
        for (int e = 1; e <= 14; e++) begin
            in_valids = (e < hold || e == ov_edge) ? '1 : '0;
            if (e == ov_edge)
                layer_in = ~frame;
            stall = stall_mask[e];
            tick();
            exp_v = e >= 2 && k < N && !stall_mask[e];
            check("valid", 32'(data_valid), 32'(exp_v));
            if (exp_v) begin
                check("addr", addr_out, k);
                check("data", 32'(data_out), 32'(want[k*W +: W]));
                k++;
            end
            check("done", 32'(done), 32'(e == done_edge));
            check("busy", 32'(busy), 32'(e >= 1 && e <= done_edge));
            if (ov_edge == 0)
                check("overrun", 32'(overrun), 0);
            else if (e != ov_edge)
                check("overrun", 32'(overrun), 32'(e > ov_edge));
        end
        check("elements", k, N);
        in_valids = '0;
        stall     = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valids = '0;
        layer_in  = '0;
        stall     = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b1;
        tick();

        run_frame(FRAME_A, EXP_A, 16'h0000, 6, 1, 0);
        run_frame(FRAME_B, EXP_B, 16'h0018, 8, 1, 0);
        run_frame(FRAME_A, EXP_A, 16'h0000, 6, 10, 0);

        in_valids = 4'h7;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("partial_busy", 32'(busy), 0);
            check("partial_valid", 32'(data_valid), 0);
        end
        in_valids = '0;
        tick();

        run_frame(FRAME_A, EXP_A, 16'h0000, 6, 1, 3);

        layer_in  = FRAME_A;
        in_valids = '1;
        tick();
        in_valids = '0;
        tick();
        tick();
        check("pre_rst_valid", 32'(data_valid), 1);
        check("pre_rst_data", 32'(data_out), 32'h0001);
        rst = 1'b0;
        tick();
        check_cleared("mid_rst");
        rst = 1'b1;
        tick();
        run_frame(FRAME_A, EXP_A, 16'h0000, 6, 1, 0);

        rst       = 1'b0;
        in_valids = '1;
        tick();
        check("rst_hold_busy", 32'(busy), 0);
        rst = 1'b1;
        run_frame(FRAME_B, EXP_B, 16'h0000, 6, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
# layer_serializer

Converts the parallel output word of one fully-connected layer back into the one-element-per-cycle stream that the next layer consumes. It captures all neuron outputs when the layer reports every neuron valid, then replays them in index order. Each replayed element carries a `data_out`/`data_valid` pair plus the matching `addr_out` weight index. It sits between two layer instances in the network chain and is the producer side of the serial input protocol that each layer receives.

## Interface
- `NUM_NEURONS`, 128: number of upstream neurons, which is also the stream length.
- `DATA_WIDTH`, 16: width of each element, two's-complement fixed point.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `in_valids`, input, `NUM_NEURONS`: per-neuron valid flags from the upstream layer.
- `layer_in`, input, `NUM_NEURONS*DATA_WIDTH`: neuron i is at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `stall`, input, 1: downstream hold request; no element is issued in any cycle where it is high.
- `data_out`, output, `DATA_WIDTH`: current stream element.
- `data_valid`, output, 1: `data_out`/`addr_out` are valid this cycle.
- `addr_out`, output, 32: element index 0..`NUM_NEURONS`-1, zero-extended.
- `busy`, output, 1: high while in LOAD, STREAM or DONE.
- `done`, output, 1: one-cycle pulse after the last element has been issued.
- `overrun`, output, 1: sticky flag, set when a capture arrives while busy.

## Operation
- **Trigger.**
  - `all_v = &in_valids`; `trig = all_v & ~all_v_q`, where `all_v_q` is `all_v` registered.
  - `trig` is a rising-edge event, so a level held high for several cycles produces one trigger.
- **FSM states:** IDLE, LOAD, STREAM, DONE.
- **IDLE.**
  - On `trig`, `layer_in` is copied into a `NUM_NEURONS` x `DATA_WIDTH` buffer, `idx` is cleared to 0, and the FSM goes to LOAD.
- **LOAD.** One cycle. Goes unconditionally to STREAM.
- **STREAM.**
  - When `stall`=0: `data_valid`=1, `data_out`=buf[idx], `addr_out`=idx.
    - If idx = `NUM_NEURONS`-1, the FSM goes to DONE.
    - Otherwise idx increments by 1.
  - When `stall`=1: `data_valid`=0 and idx holds.
  - Elements are never skipped or repeated.
- **DONE.** `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- **Outputs.** `data_out` and `addr_out` are registered. They hold their last values when `data_valid`=0; downstream logic must ignore them in that case.
- **Overrun.**
  - A `trig` in LOAD, STREAM or DONE sets `overrun` and is otherwise ignored.
  - The buffer is not modified and the current stream completes unaltered.
  - `overrun` clears only on reset.
- **Simultaneous events.** `trig` in the same cycle as the DONE→IDLE transition counts as an overrun; it is not a new capture.
- **Width rules.**
  - `idx` is `$clog2(NUM_NEURONS)` bits, with a minimum of 1 bit.
  - `NUM_NEURONS`=1 is legal: the stream is a single element, and STREAM goes straight to DONE.
- **Reset** (`rst`=0 at a clock edge, in any state, including mid-stream):
  - FSM returns to IDLE; idx=0; `all_v_q`=0.
  - `data_valid`=0, `data_out`=0, `addr_out`=0, `busy`=0, `done`=0, `overrun`=0.
  - Buffer contents are don't-care.
  - If `in_valids` is all-high when reset releases, a trigger is generated on the first cycle out of reset.

## Timing
- Capture happens at the edge where `trig` is sampled; call this cycle T.
- LOAD occupies T+1.
- With no stalls, the first `data_valid` is at T+2 and element k is issued at T+2+k.
- `done` is at T+2+`NUM_NEURONS`, and the FSM is back in IDLE at T+3+`NUM_NEURONS`.
- Each stall cycle pushes all later elements and `done` back by one cycle.
- `busy` is high from T+1 through the `done` cycle inclusive.
- Throughput is at most one frame per `NUM_NEURONS`+3 cycles.

## Configuration
- **`LAYER_SER_RELU_EN` defined:**
  - Each element is passed through ReLU on issue: if buf[idx] is negative (MSB=1), `data_out`=0; otherwise `data_out`=buf[idx].
  - Adds no latency; the function is applied within the output register stage.
- **`LAYER_SER_RELU_EN` undefined:** `data_out` is the raw buffered value.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `NUM_NEURONS`=4 and `DATA_WIDTH`=16.
- **Basic frame.** `layer_in` = {0x0004, 0x0003, 0xFFFE, 0x0001} (neurons 3..0), `in_valids`=4'hF for one cycle at T, no stall.
  - Expect `data_valid` at T+2..T+5.
  - Expect `addr_out` = 0,1,2,3.
  - Expect `data_out` = 0x0001, 0xFFFE, 0x0003, 0x0004. With `LAYER_SER_RELU_EN` defined, the second element is 0x0000.
  - Expect `done` at T+6.
- **Stall.** Same frame, `stall`=1 at T+3 and T+4.
  - Expect element 1 to be issued at T+5.
  - Expect `done` at T+8.
  - Expect `data_valid`=0 during both stall cycles.
- **Held valid level and partial valid.**
  - `in_valids`=4'hF held for 10 cycles → exactly one frame and no `overrun`.
  - `in_valids`=4'h7 → no trigger; `busy` stays 0.
- **Overrun.** A second rising `in_valids` edge at T+3, carrying different data.
  - Expect `overrun`=1 from T+4.
  - Expect the stream still to carry the first frame's values unchanged.
- **Reset mid-stream.** `rst`=0 at T+3.
  - Expect all outputs 0 and `busy`=0 on the next cycle.
  - A new trigger after reset yields a full 4-element frame starting at `addr_out`=0.
